// File: rtl/buffer_reader.sv
// buffer_reader: read-side controller for the circular Buffer store.
//
// Owns the read pointer (driven to the store as o_raddr), tracks occupancy from
// the writer's commit strobes, reports free space back to the writer and streams
// PAR_READ-wide windows of the store's combinational read data onto a registered
// valid/ready output. The pointer advances by a clamped per-window stride, so
// consecutive windows may overlap (sliding-window feed).
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_clear      synchronous flush of pointer, occupancy, output valid and overflow
//   i_wen        writer commits i_wr_num elements at this edge
//   i_wr_num     element count of this commit, 0..PAR_WRITE
//   i_stride     pointer advance per emitted window, 1..PAR_READ (0 acts as 1)
//   o_raddr      read address to the store (the read pointer)
//   i_buf_dout   store read data for o_raddr, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_out_data   registered window
//   o_out_valid  o_out_data holds a valid window
//   i_out_ready  consumer accepts the window this cycle
//   o_count      elements held and not yet released
//   o_free       DEPTH - o_count (DEPTH while in reset)
//   o_overflow   sticky: a commit exceeded the available space

module buffer_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 1,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_clear,
  input  logic                           i_wen,
  input  logic [$clog2(PAR_WRITE):0]     i_wr_num,
  input  logic [$clog2(PAR_READ):0]      i_stride,
  output logic [ADDR_WIDTH-1:0]          o_raddr,
  input  logic [PAR_READ*DATA_WIDTH-1:0] i_buf_dout,
  output logic [PAR_READ*DATA_WIDTH-1:0] o_out_data,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [CNT_WIDTH-1:0]           o_count,
  output logic [CNT_WIDTH-1:0]           o_free,
  output logic                           o_overflow
);

  localparam int unsigned StrWidth    = $clog2(PAR_READ) + 1;
  localparam int unsigned SumWidth    = CNT_WIDTH + 1;
  localparam int unsigned PtrSumWidth = ADDR_WIDTH + 1;

  // Registers
  logic [ADDR_WIDTH-1:0]          r_rptr;
  logic [CNT_WIDTH-1:0]           r_count;
  logic [PAR_READ*DATA_WIDTH-1:0] r_out_data;
  logic                           r_out_valid;
  logic                           r_overflow;

  // Combinational next-state terms
  logic [StrWidth-1:0]    w_step;
  logic                   w_slot_open;
  logic                   w_load;
  logic [CNT_WIDTH-1:0]   w_free;
  logic [SumWidth-1:0]    w_commit;
  logic [SumWidth-1:0]    w_release;
  logic [SumWidth-1:0]    w_count_sum;
  logic [CNT_WIDTH-1:0]   w_count_next;
  logic                   w_ovf_hit;
  logic [PtrSumWidth-1:0] w_ptr_sum;
  logic [ADDR_WIDTH-1:0]  w_rptr_next;

  // Stride clamped to 1..PAR_READ.
  always_comb begin
    w_step = i_stride;
    if (i_stride == '0) begin
      w_step = StrWidth'(1);
    end else if (i_stride > StrWidth'(PAR_READ)) begin
      w_step = StrWidth'(PAR_READ);
    end
  end

  // Load decision uses the registered count only; a commit at this same edge
  // becomes visible one cycle later.
  assign w_slot_open = !r_out_valid || i_out_ready;
  assign w_load      = w_slot_open && (r_count >= CNT_WIDTH'(PAR_READ));

  assign w_free    = CNT_WIDTH'(DEPTH) - r_count;
  assign w_commit  = i_wen ? SumWidth'(i_wr_num) : '0;
  assign w_release = w_load ? SumWidth'(w_step) : '0;

  // w_release never exceeds r_count, so the sum cannot underflow; it can exceed
  // DEPTH only on overflow, where the count pins at DEPTH.
  assign w_count_sum  = SumWidth'(r_count) + w_commit - w_release;
  assign w_count_next = (w_count_sum > SumWidth'(DEPTH)) ? CNT_WIDTH'(DEPTH)
                                                         : CNT_WIDTH'(w_count_sum);

  // Space released by a load at this edge is usable by a commit at the same edge.
  assign w_ovf_hit = i_wen && (SumWidth'(i_wr_num) > SumWidth'(w_free) + w_release);

  // Wrap by one subtraction so DEPTH need not be a power of two.
  assign w_ptr_sum   = PtrSumWidth'(r_rptr) + PtrSumWidth'(w_step);
  assign w_rptr_next = (w_ptr_sum >= PtrSumWidth'(DEPTH))
                       ? ADDR_WIDTH'(w_ptr_sum - PtrSumWidth'(DEPTH))
                       : ADDR_WIDTH'(w_ptr_sum);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (i_clear) begin
      // Output data is left as-is; only its valid flag is dropped.
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= i_buf_dout;
        r_out_valid <= 1'b1;
        r_rptr      <= w_rptr_next;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_count <= w_count_next;
      if (w_ovf_hit) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_raddr     = r_rptr;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_count     = r_count;
  assign o_free      = i_rst ? CNT_WIDTH'(DEPTH) : w_free;
  assign o_overflow  = r_overflow;

endmodule
